// File: rtl/usr_shift_reg.sv
// -----------------------------------------------------------------------------
// usr_shift_reg -- parametrised universal shift register with serialiser
//
// A general-purpose WIDTH-bit register that supports hold, right/left shift
// with serial fill, parallel load and clear. It also has a small sequencer that
// loads a word and shifts it out one bit per clock on ser_o.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   LSB_FIRST  1: serialiser shifts right, ser_o = data_o[0]
//              0: serialiser shifts left,  ser_o = data_o[WIDTH-1]
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset; aborts a serialisation silently
//   mode_i     manual op select (HOLD/SHR/SHL/LOAD/CLR/ROTR/ROTL/HOLD);
//              ignored while busy_o=1
//   data_i     parallel load data for LOAD and for start_i
//   ser_msb_i  fill bit entering the MSB on a right shift
//   ser_lsb_i  fill bit entering the LSB on a left shift
//   start_i    begin a serialisation; sampled only while idle, beats mode_i
//   data_o     register contents
//   ser_o      serial output, combinational from data_o
//   busy_o     high for exactly WIDTH cycles while the serialiser runs
//   done_o     one-cycle pulse in the cycle after the last serial bit
//
// Configuration
//   USR_ROTATE_EN  when defined, modes 101/110 rotate right/left by one.
//                  When undefined they behave as HOLD and no rotate logic
//                  is built. The serialiser is unaffected either way.
// -----------------------------------------------------------------------------
module usr_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ser_msb_i,
    input  logic             ser_lsb_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_CLR   = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ROTL  = 3'b110,
        MODE_HOLD7 = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] manual_val;

    // Fill-bit shifts shared by the manual modes and the serialiser.
    assign shr_val   = {ser_msb_i, data_o[WIDTH-1:1]};
    assign shl_val   = {data_o[WIDTH-2:0], ser_lsb_i};
    assign shift_val = LSB_FIRST ? shr_val : shl_val;

    assign ser_o = LSB_FIRST ? data_o[0] : data_o[WIDTH-1];

    // Next register value for the manual modes (idle, no start).
    always_comb begin
        // NOTE: default assignment first so every path drives manual_val and
        // no latch is inferred for the unlisted/HOLD codes.
        manual_val = data_o;
        case (mode_e'(mode_i))
            MODE_SHR:  manual_val = shr_val;
            MODE_SHL:  manual_val = shl_val;
            MODE_LOAD: manual_val = data_i;
            MODE_CLR:  manual_val = '0;
`ifdef USR_ROTATE_EN
            MODE_ROTR: manual_val = {data_o[0], data_o[WIDTH-1:1]};
            MODE_ROTL: manual_val = {data_o[WIDTH-2:0], data_o[WIDTH-1]};
`endif
            default:   manual_val = data_o;
        endcase
    end

    // Sequencer and register. busy_o/done_o are registered so they align
    // with the cycles in which the shifted data is visible on ser_o.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            data_o  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            count_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        data_o  <= data_i;
                        busy_o  <= 1'b1;
                        count_q <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        data_o <= manual_val;
                    end
                end
                ST_SHIFT: begin
                    data_o <= shift_val;
                    if (count_q == CNT_LAST) begin
                        // Last of WIDTH shifts: counter returns to zero so it
                        // never holds a value above WIDTH-1.
                        count_q <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    count_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_usr_shift_reg -- self-checking bench for usr_shift_reg (WIDTH=8)
//
// Two instances share all inputs: one with LSB_FIRST=1, one with LSB_FIRST=0.
// A behavioural model tracks register value, remaining serial bits and the
// done pulse for each; directed scenarios are followed by random traffic.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_usr_shift_reg;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [2:0]   mode_i;
    logic [W-1:0] data_i;
    logic         ser_msb_i;
    logic         ser_lsb_i;
    logic         start_i;

    logic [W-1:0] data_l, data_m;
    logic         ser_l, ser_m, busy_l, busy_m, done_l, done_m;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = LSB-first instance, 1 = MSB-first instance.
    logic [W-1:0] m_data [2];
    int           m_left [2];
    logic         m_done [2];

    always #5 clk_i = ~clk_i;

    usr_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .data_i(data_i),
        .ser_msb_i(ser_msb_i), .ser_lsb_i(ser_lsb_i), .start_i(start_i),
        .data_o(data_l), .ser_o(ser_l), .busy_o(busy_l), .done_o(done_l)
    );

    usr_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .data_i(data_i),
        .ser_msb_i(ser_msb_i), .ser_lsb_i(ser_lsb_i), .start_i(start_i),
        .data_o(data_m), .ser_o(ser_m), .busy_o(busy_m), .done_o(done_m)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Arithmetic view of one clock edge for one instance.
    task automatic model_step(input int d);
        int v;
        v = m_data[d];
        if (rst_i) begin
            m_data[d] = '0;
            m_left[d] = 0;
            m_done[d] = 1'b0;
        end else if (m_left[d] > 0) begin
            if (d == 0) v = (v >> 1) + (ser_msb_i ? 128 : 0);
            else        v = ((v * 2) % 256) + (ser_lsb_i ? 1 : 0);
            m_data[d] = v[W-1:0];
            m_left[d] = m_left[d] - 1;
            m_done[d] = (m_left[d] == 0);
        end else begin
            m_done[d] = 1'b0;
            if (start_i) begin
                m_data[d] = data_i;
                m_left[d] = W;
            end else begin
                case (mode_i)
                    3'd1: v = (v >> 1) + (ser_msb_i ? 128 : 0);
                    3'd2: v = ((v * 2) % 256) + (ser_lsb_i ? 1 : 0);
                    3'd3: v = data_i;
                    3'd4: v = 0;
`ifdef USR_ROTATE_EN
                    3'd5: v = (v >> 1) + ((v % 2) * 128);
                    3'd6: v = ((v * 2) % 256) + (v / 128);
`endif
                    default: ;
                endcase
                m_data[d] = v[W-1:0];
            end
        end
    endtask

    // Advance one clock and compare every output of both instances.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("lsb.data", data_l, m_data[0]);
        check("lsb.ser",  ser_l,  m_data[0][0]);
        check("lsb.busy", busy_l, m_left[0] > 0);
        check("lsb.done", done_l, m_done[0]);
        check("msb.data", data_m, m_data[1]);
        check("msb.ser",  ser_m,  m_data[1][W-1]);
        check("msb.busy", busy_m, m_left[1] > 0);
        check("msb.done", done_m, m_done[1]);
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; start_i = 1'b0; mode_i = 3'b000;
        ser_msb_i = 1'b0; ser_lsb_i = 1'b0;
    endtask

    logic [W-1:0] s_l, s_m;
    int           n_busy;

    initial begin
        m_data = '{default: '0};
        m_left = '{default: 0};
        m_done = '{default: 1'b0};

        // 1. Reset with random inputs on the other pins.
        rst_i = 1'b1; start_i = 1'($urandom); mode_i = 3'($urandom);
        data_i = 8'($urandom); ser_msb_i = 1'($urandom); ser_lsb_i = 1'($urandom);
        tick();
        check("reset.data", data_l, 8'h00);
        check("reset.busy", busy_l, 1'b0);
        check("reset.done", done_l, 1'b0);
        idle_inputs();

        // 2. Manual ops.
        mode_i = 3'b011; data_i = 8'hA5; tick(); check("load", data_l, 8'hA5);
        mode_i = 3'b001; ser_msb_i = 1'b1; tick(); check("shr", data_l, 8'hD2);
        mode_i = 3'b010; ser_lsb_i = 1'b0; ser_msb_i = 1'b0; tick(); check("shl", data_l, 8'hA4);
        mode_i = 3'b100; tick(); check("clr", data_l, 8'h00);
        mode_i = 3'b000;
        for (int i = 0; i < 3; i++) begin tick(); check("hold", data_l, 8'h00); end

        // 3. Serialise B4 with zero fills; capture both streams.
        data_i = 8'hB4; start_i = 1'b1; tick(); start_i = 1'b0;
        n_busy = 0;
        for (int k = 0; k < W; k++) begin
            s_l[k] = ser_l; s_m[k] = ser_m;
            if (busy_l) n_busy++;
            tick();
        end
        check("stream.lsb", s_l, 8'hB4);  // 0,0,1,0,1,1,0,1 in cycle order
        check("stream.msb", s_m, 8'h2D);  // 1,0,1,1,0,1,0,0 in cycle order
        check("busy.len", n_busy, W);
        check("done.pulse", done_l, 1'b1);
        check("done.data", data_l, 8'h00);
        tick();
        check("done.once", done_l, 1'b0);

        // 4. Busy lockout, then back-to-back start in the done cycle.
        data_i = 8'hB4; start_i = 1'b1; tick();
        n_busy = 0;
        for (int k = 0; k < W; k++) begin
            s_l[k] = ser_l; s_m[k] = ser_m;
            if (busy_l) n_busy++;
            start_i = 1'b1; data_i = 8'hFF; mode_i = (k % 2) ? 3'b011 : 3'b100;
            tick();
        end
        check("lock.stream.lsb", s_l, 8'hB4);
        check("lock.stream.msb", s_m, 8'h2D);
        check("lock.busy.len", n_busy, W);
        check("lock.done", done_m, 1'b1);
        data_i = 8'h3C; start_i = 1'b1; mode_i = 3'b000; tick();
        check("b2b.busy", busy_l, 1'b1);
        check("b2b.data", data_m, 8'h3C);
        start_i = 1'b0;
        for (int k = 0; k < W + 1; k++) tick();

        // 5. Reset during the 3rd busy cycle.
        data_i = 8'h5A; start_i = 1'b1; tick(); start_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("abort.data", data_l, 8'h00);
        check("abort.busy", busy_m, 1'b0);
        for (int k = 0; k < W; k++) begin
            tick();
            check("abort.nodone", done_l, 1'b0);
        end

        // 6. Rotate modes.
        mode_i = 3'b011; data_i = 8'h81; tick();
        mode_i = 3'b101; tick();
`ifdef USR_ROTATE_EN
        check("rotr", data_l, 8'hC0);
`else
        check("rotr.hold", data_l, 8'h81);
`endif
        mode_i = 3'b110; tick();
        check("rotl", data_l, 8'h81);

        // 7. Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_i     = ($urandom_range(0, 39) == 0);
            start_i   = ($urandom_range(0, 7) == 0);
            mode_i    = 3'($urandom);
            data_i    = 8'($urandom);
            ser_msb_i = 1'($urandom);
            ser_lsb_i = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
